scale_down2x: RTL and testbench

2:1 box-filter decimator for the video path: each 2x2 block of input pixels is averaged into one output pixel, halving width and height. It is the reverse-direction companion to the 2x upscaler. It uses the same pixel stream conventions: `ce_in` pixel strobe, `reset_line`/`reset_frame` line and frame markers, and 12-bit or 24-bit packed RGB. It sits between a core's video output and a half-resolution consumer such as a thumbnail or capture path. It holds one line of horizontal pair sums in block RAM.

---
 rtl/scale_down2x.sv | 137 +++++++++++++
 tb/tb_scale_down2x.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/scale_down2x.sv
// 2x2 box-filter decimator: averages each 2x2 input block into one output pixel.
// Latency: out_valid one clk after the edge sampling the odd pixel of an odd line.
// Backpressure: none; the consumer must accept every one-clk out_valid pulse.
//
// Ports:
//   clk, reset_n              - clock, asynchronous active-low reset
//   ce_in, inputpixel         - pixel strobe and packed RGB pixel
//   reset_line, reset_frame   - horizontal / vertical blank markers
//   out_valid, outpixel       - one-clk output pulse and averaged pixel
//   out_x, out_first          - output pixel index, high when out_x==0
// Optional feature macro: SCALE_DOWN2X_ROUND_EN (round-half-up instead of truncation).
module scale_down2x #(
    parameter int LENGTH     = 1024,
    parameter int HALF_DEPTH = 0,
    localparam int DW        = (HALF_DEPTH != 0) ? 12 : 24,
    localparam int AW        = $clog2(LENGTH) - 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_in,
    input  logic [DW-1:0] inputpixel,
    input  logic          reset_line,
    input  logic          reset_frame,
    output logic          out_valid,
    output logic [DW-1:0] outpixel,
    output logic [AW-1:0] out_x,
    output logic          out_first
);
    localparam int CW    = DW / 3;      // channel width
    localparam int HW    = CW + 1;      // horizontal pair sum width
    localparam int VW    = CW + 2;      // 2x2 sum width
    localparam int RW    = 3 * HW;      // line RAM word width
    localparam int DEPTH = LENGTH / 2;
    localparam logic [AW:0] MAX_X = (AW+1)'(LENGTH - 1);

    logic [AW:0]   x_q, x_d, cur_x;
    logic          sat_q, sat_d, cur_sat;
    logic          par_q, cur_par;
    logic [AW:0]   pairs_prev_q;
    logic          rl_q, rf_q;
    logic [DW-1:0] hold_q;
    logic [RW-1:0] ram_q;
    logic [RW-1:0] mem [DEPTH];

    logic          line_start, frame_start, pix_ok, is_odd;
    logic          wr_en, rd_en, emit;
    logic [AW-1:0] addr;
    logic [RW-1:0] hs_all;
    logic [DW-1:0] res;
    logic [HW-1:0] hs_c;
    logic [VW-1:0] vs_c;

    // A line starts on the falling edge of reset_line as seen by ce_in; the
    // pixel on that same strobe already belongs to the new line, so the
    // "current" line state is the post-line-start view.
    assign line_start  = ce_in & rl_q & ~reset_line;
    assign frame_start = ce_in & rf_q & ~reset_frame;
    assign cur_x       = line_start ? '0 : x_q;
    assign cur_sat     = line_start ? 1'b0 : sat_q;
    assign cur_par     = line_start ? (frame_start ? 1'b0 : ~par_q) : par_q;

    // Pixels during horizontal blank or past the saturated end are ignored.
    assign pix_ok = ce_in & ~reset_line & ~cur_sat;
    assign is_odd = cur_x[0];
    assign addr   = cur_x[AW:1];
    assign rd_en  = pix_ok & ~is_odd;
    assign wr_en  = pix_ok & is_odd & ~cur_par;
    // Entries at or beyond the previous even line's pair count are stale.
    assign emit   = pix_ok & is_odd & cur_par & ({1'b0, addr} < pairs_prev_q);

    always_comb begin
        hs_all = '0;
        res    = '0;
        hs_c   = '0;
        vs_c   = '0;
        for (int c = 0; c < 3; c++) begin
            hs_c = HW'(hold_q[c*CW +: CW]) + HW'(inputpixel[c*CW +: CW]);
            vs_c = VW'(hs_c) + VW'(ram_q[c*HW +: HW]);
`ifdef SCALE_DOWN2X_ROUND_EN
            // Max 4*full-scale + 2 still fits in VW bits.
            vs_c = vs_c + VW'(2);
`endif
            hs_all[c*HW +: HW] = hs_c;
            res[c*CW +: CW]    = vs_c[VW-1:2];
        end
    end

    always_comb begin
        x_d   = cur_x;
        sat_d = cur_sat;
        if (pix_ok) begin
            if (cur_x == MAX_X) sat_d = 1'b1;
            else                x_d   = cur_x + 1'b1;
        end
    end

    // Line RAM: simple dual-port, registered read, never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= hs_all;
        if (rd_en) ram_q     <= mem[addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q          <= '0;
            sat_q        <= 1'b0;
            par_q        <= 1'b0;
            pairs_prev_q <= '0;
            rl_q         <= 1'b0;
            rf_q         <= 1'b0;
            hold_q       <= '0;
            out_valid    <= 1'b0;
            outpixel     <= '0;
            out_x        <= '0;
            out_first    <= 1'b0;
        end else begin
            x_q   <= x_d;
            sat_q <= sat_d;
            if (ce_in) begin
                rl_q <= reset_line;
                rf_q <= reset_frame;
            end
            if (line_start) begin
                par_q <= cur_par;
                if (!par_q)
                    pairs_prev_q <= sat_q ? (AW+1)'(DEPTH) : (x_q >> 1);
            end
            if (rd_en) hold_q <= inputpixel;
            out_valid <= emit;
            out_first <= emit & (addr == '0);
            if (emit) begin
                outpixel <= res;
                out_x    <= addr;
            end
        end
    end
endmodule

// File: tb/tb_scale_down2x.sv
module tb_scale_down2x;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_in = 1'b0;
    logic [23:0] px24 = '0;
    logic [11:0] px12 = '0;
    logic        reset_line = 1'b0;
    logic        reset_frame = 1'b0;

    logic        ov24, of24, ov12, of12;
    logic [23:0] op24;
    logic [11:0] op12;
    logic [8:0]  ox24, ox12;

    int pass_cnt = 0;
    int total_cnt = 0;
    int vcount = 0;
    logic [8:0]  last_x;
    logic [23:0] last_pix;

    always #5 clk = ~clk;

    scale_down2x #(.LENGTH(1024), .HALF_DEPTH(0)) dut (
        .clk(clk), .reset_n(reset_n), .ce_in(ce_in), .inputpixel(px24),
        .reset_line(reset_line), .reset_frame(reset_frame),
        .out_valid(ov24), .outpixel(op24), .out_x(ox24), .out_first(of24));

    scale_down2x #(.LENGTH(1024), .HALF_DEPTH(1)) dut_h (
        .clk(clk), .reset_n(reset_n), .ce_in(ce_in), .inputpixel(px12),
        .reset_line(reset_line), .reset_frame(reset_frame),
        .out_valid(ov12), .outpixel(op12), .out_x(ox12), .out_first(of12));

    // Counts 24-bit output pulses, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (ov24) begin
            vcount++;
            last_x   = ox24;
            last_pix = op24;
        end
    end

    // Drive one pixel strobe; called and returning at a falling edge.
    task automatic send(input logic [23:0] p, input logic [11:0] q);
        ce_in = 1'b1; px24 = p; px12 = q;
        @(negedge clk);
        ce_in = 1'b0;
    endtask

    // One blank strobe, so the next send() sees a reset_line falling edge.
    task automatic blank(input logic frame);
        ce_in = 1'b1; reset_line = 1'b1; reset_frame = frame;
        @(negedge clk);
        ce_in = 1'b0; reset_line = 1'b0; reset_frame = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (ov24 !== 1'b0) $display("FAIL reset_valid got %b want 0", ov24); else pass_cnt++;
        total_cnt++; if (op24 !== 24'h0) $display("FAIL reset_pixel got %h want 000000", op24); else pass_cnt++;
        total_cnt++; if (ox24 !== 9'd0) $display("FAIL reset_x got %0d want 0", ox24); else pass_cnt++;
        total_cnt++; if (of24 !== 1'b0) $display("FAIL reset_first got %b want 0", of24); else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int v0;
        v0 = vcount;
        blank(1'b1);
        send(24'h000000, 12'h000); send(24'h040404, 12'h444);
        blank(1'b0);
        send(24'h080808, 12'h888);
        total_cnt++; if (ov24 !== 1'b0) $display("FAIL basic_early got %b want 0", ov24); else pass_cnt++;
        send(24'h0C0C0C, 12'hCCC);
        total_cnt++; if (ov24 !== 1'b1) $display("FAIL basic_valid got %b want 1", ov24); else pass_cnt++;
        total_cnt++; if (op24 !== 24'h060606) $display("FAIL basic_pixel got %h want 060606", op24); else pass_cnt++;
        total_cnt++; if (ox24 !== 9'd0) $display("FAIL basic_x got %0d want 0", ox24); else pass_cnt++;
        total_cnt++; if (of24 !== 1'b1) $display("FAIL basic_first got %b want 1", of24); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (ov24 !== 1'b0) $display("FAIL basic_pulse_width got %b want 0", ov24); else pass_cnt++;
        total_cnt++; if (vcount - v0 !== 1) $display("FAIL basic_count got %0d want 1", vcount - v0); else pass_cnt++;
    endtask

    task automatic test_rounding;
        logic [23:0] exp;
`ifdef SCALE_DOWN2X_ROUND_EN
        exp = 24'h010101;
`else
        exp = 24'h000000;
`endif
        blank(1'b1);
        send(24'h010101, 12'h111); send(24'h010101, 12'h111);
        blank(1'b0);
        send(24'h010101, 12'h111); send(24'h000000, 12'h000);
        total_cnt++; if (ov24 !== 1'b1) $display("FAIL round_valid got %b want 1", ov24); else pass_cnt++;
        total_cnt++; if (op24 !== exp) $display("FAIL round_pixel got %h want %h", op24, exp); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_extremes;
        blank(1'b1);
        send(24'hFFFFFF, 12'hFFF); send(24'hFFFFFF, 12'hFFF);
        blank(1'b0);
        send(24'hFFFFFF, 12'hFFF); send(24'hFFFFFF, 12'hFFF);
        total_cnt++; if (op24 !== 24'hFFFFFF) $display("FAIL extreme24 got %h want FFFFFF", op24); else pass_cnt++;
        total_cnt++; if (ov12 !== 1'b1) $display("FAIL extreme12_valid got %b want 1", ov12); else pass_cnt++;
        total_cnt++; if (op12 !== 12'hFFF) $display("FAIL extreme12 got %h want FFF", op12); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_length_mismatch;
        int v0;
        v0 = vcount;
        blank(1'b1);
        for (int i = 0; i < 3; i++) send(24'h101010, 12'h111);
        blank(1'b0);
        for (int i = 0; i < 6; i++) send(24'h202020, 12'h222);
        repeat (2) @(negedge clk);
        total_cnt++; if (vcount - v0 !== 1) $display("FAIL mismatch_count got %0d want 1", vcount - v0); else pass_cnt++;
        total_cnt++; if (last_x !== 9'd0) $display("FAIL mismatch_x got %0d want 0", last_x); else pass_cnt++;
        total_cnt++; if (last_pix !== 24'h181818) $display("FAIL mismatch_pixel got %h want 181818", last_pix); else pass_cnt++;
    endtask

    task automatic test_frame_reset;
        int v0;
        blank(1'b1);
        for (int i = 0; i < 4; i++) send(24'h101010, 12'h111);
        blank(1'b0);
        for (int i = 0; i < 4; i++) send(24'h101010, 12'h111);
        blank(1'b0);
        for (int i = 0; i < 4; i++) send(24'h555555, 12'h555);
        @(negedge clk);
        v0 = vcount;
        blank(1'b1);
        for (int i = 0; i < 4; i++) send(24'h202020, 12'h222);
        @(negedge clk);
        total_cnt++; if (vcount - v0 !== 0) $display("FAIL frame_even_count got %0d want 0", vcount - v0); else pass_cnt++;
        blank(1'b0);
        for (int i = 0; i < 4; i++) send(24'h404040, 12'h444);
        @(negedge clk);
        total_cnt++; if (vcount - v0 !== 2) $display("FAIL frame_odd_count got %0d want 2", vcount - v0); else pass_cnt++;
        total_cnt++; if (last_x !== 9'd1) $display("FAIL frame_last_x got %0d want 1", last_x); else pass_cnt++;
        total_cnt++; if (last_pix !== 24'h303030) $display("FAIL frame_pixel got %h want 303030", last_pix); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        int v0;
        blank(1'b1);
        for (int i = 0; i < 4; i++) send(24'h101010, 12'h111);
        blank(1'b0);
        send(24'h101010, 12'h111); send(24'h101010, 12'h111);
        total_cnt++; if (ov24 !== 1'b1) $display("FAIL arst_pre_valid got %b want 1", ov24); else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++; if (ov24 !== 1'b0) $display("FAIL arst_valid got %b want 0", ov24); else pass_cnt++;
        total_cnt++; if (op24 !== 24'h0) $display("FAIL arst_pixel got %h want 000000", op24); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        v0 = vcount;
        send(24'h808080, 12'h888); send(24'h808080, 12'h888);
        @(negedge clk);
        total_cnt++; if (vcount - v0 !== 0) $display("FAIL arst_after_count got %0d want 0", vcount - v0); else pass_cnt++;
        blank(1'b0);
        send(24'h404040, 12'h444); send(24'h404040, 12'h444);
        @(negedge clk);
        total_cnt++; if (vcount - v0 !== 1) $display("FAIL arst_odd_count got %0d want 1", vcount - v0); else pass_cnt++;
        total_cnt++; if (last_pix !== 24'h606060) $display("FAIL arst_odd_pixel got %h want 606060", last_pix); else pass_cnt++;
        total_cnt++; if (last_x !== 9'd0) $display("FAIL arst_odd_x got %0d want 0", last_x); else pass_cnt++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_rounding();
        test_extremes();
        test_length_mismatch();
        test_frame_reset();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
